// File: rtl/debug_panel_mk2_if.sv
// Purpose : CPU data-port bundle between the CPU and the debug panel.
// Latency : none, wires only; rdata is a combinational return path.
// Backpr. : none, a single-cycle strobe port with no stall signal.
// Signals : enw (write enable), address (word address), wdata (write data) from master;
//           rdata (read data) from slave.
interface debug_panel_mk2_if #(
  parameter int WIDTH = 32
);
  logic             enw;
  logic [WIDTH-1:0] address;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;

  modport master (output enw, output address, output wdata, input  rdata);
  modport slave  (input  enw, input  address, input  wdata, output rdata);
endinterface

// File: rtl/debug_panel_mk2.sv
// Purpose : debug panel owning the data RAM; muxes CPU/panel access and drives a hex display.
// Latency : button to effect DB+1 cycles; register write to display 1 cycle; rdata combinational.
// Backpr. : none; the CPU port never stalls, and writes in panel mode are silently dropped.
// Ports   : clk, nrst (async active-low); cpu (slave: enw/address/wdata in, rdata out);
//           button[3:0] active-low {PREV,NEXT,MODE,GO}; seg[NDATA+NADDR-1:0] active-low gfedcba
//           digits, [0] = least-significant data digit; mode_led = 1 in panel mode.
module debug_panel_mk2 #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 100_000,
  parameter int CLKRATE   = 25_000_000,
  parameter int DBMSEC    = 150,
  parameter int RPTMSEC   = 500,
  parameter int NDATA     = 4,
  parameter int NADDR     = 2,
  parameter int GO_ADDR   = 100_001,
  parameter int DISP_ADDR = 100_002
) (
  input  logic                         clk,
  input  logic                         nrst,
  debug_panel_mk2_if.slave             cpu,
  input  logic [3:0]                   button,
  output logic [NDATA+NADDR-1:0][6:0]  seg,
  output logic                         mode_led
);

  localparam int DB     = CLKRATE / 1000 * DBMSEC;
  localparam int RH     = CLKRATE / 1000 * RPTMSEC;
  localparam int RP     = RH / 4;
  localparam int CMAX   = DB + RH + RP;
  localparam int CW     = $clog2(CMAX + 1);
  localparam int DW     = 4 * NDATA;
  localparam int NCHUNK = WIDTH / DW;
  localparam int CHW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    MODE_CPU   = 1'b0,
    MODE_PANEL = 1'b1
  } mode_e;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    s = 7'h7F;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Debounce. Each counter runs while its button is held and clears on release.
  // GO/MODE saturate at DB. NEXT/PREV keep counting to drive auto-repeat: once
  // the count would reach DB+RH+RP it folds back to DB+RH, so the repeat phase
  // is a short loop and the counter never has to hold the full hold time twice.
  // ---------------------------------------------------------------------------
  logic [3:0] w_pulse;

  genvar g;
  for (g = 0; g < 4; g++) begin : g_db
    localparam bit REPEAT = (g >= 2);
    logic [CW-1:0] r_cnt;
    logic          r_pulse;
    logic [CW-1:0] w_cnt_inc;

    assign w_cnt_inc = r_cnt + CW'(1);

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else if (button[g]) begin
        r_cnt   <= '0;
        r_pulse <= 1'b0;
      end else if (REPEAT) begin
        r_cnt   <= (w_cnt_inc == CW'(CMAX)) ? CW'(DB + RH) : w_cnt_inc;
        r_pulse <= (w_cnt_inc == CW'(DB)) || (w_cnt_inc == CW'(DB + RH)) ||
                   (w_cnt_inc == CW'(CMAX));
      end else begin
        if (r_cnt != CW'(DB)) r_cnt <= w_cnt_inc;
        r_pulse <= (w_cnt_inc == CW'(DB));
      end
    end

    assign w_pulse[g] = r_pulse;
  end

  // ---------------------------------------------------------------------------
  // CPU port decode
  // ---------------------------------------------------------------------------
  mode_e            r_mode;
  logic             r_go;
  logic [WIDTH-1:0] r_disp;
  logic [WIDTH-1:0] r_panel_address;
  logic [CHW-1:0]   r_chunk;

  logic             w_is_go;
  logic             w_is_disp;
  logic             w_cpu_wr;
  logic             w_ram_we;
  logic [WIDTH-1:0] w_ram_addr;
  logic             w_ram_in_range;
  logic [AW-1:0]    w_ram_idx;
  logic [WIDTH-1:0] w_ram_rdata;

  assign w_is_go    = (cpu.address == WIDTH'(GO_ADDR));
  assign w_is_disp  = (cpu.address == WIDTH'(DISP_ADDR));
  assign w_cpu_wr   = cpu.enw && (r_mode == MODE_CPU);
  assign w_ram_we   = w_cpu_wr && !w_is_go && !w_is_disp;
  assign w_ram_addr = (r_mode == MODE_PANEL) ? r_panel_address : cpu.address;

  always_comb begin
    cpu.rdata = '0;
    if (r_mode == MODE_CPU) begin
      if (w_is_go)        cpu.rdata = {{(WIDTH-1){1'b0}}, r_go};
      else if (w_is_disp) cpu.rdata = r_disp;
      else                cpu.rdata = w_ram_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Data RAM: synchronous write, asynchronous read. Addresses beyond DEPTH read
  // as zero and swallow writes.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] r_mem [DEPTH];

  assign w_ram_in_range = (w_ram_addr < WIDTH'(DEPTH));
  assign w_ram_idx      = w_ram_addr[AW-1:0];
  assign w_ram_rdata    = w_ram_in_range ? r_mem[w_ram_idx] : '0;

  always_ff @(posedge clk) begin
    if (w_ram_we && w_ram_in_range) r_mem[w_ram_idx] <= cpu.wdata;
  end

  // ---------------------------------------------------------------------------
  // Mode FSM, GO flag, display register and cursor
  // ---------------------------------------------------------------------------
  logic w_step_next;
  logic w_step_prev;

  // Simultaneous NEXT and PREV cancel each other.
  assign w_step_next = (r_mode == MODE_PANEL) && w_pulse[2] && !w_pulse[3];
  assign w_step_prev = (r_mode == MODE_PANEL) && w_pulse[3] && !w_pulse[2];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_mode          <= MODE_CPU;
      r_go            <= 1'b0;
      r_disp          <= '0;
      r_panel_address <= '0;
      r_chunk         <= '0;
    end else begin
      case (r_mode)
        MODE_CPU:   if (w_pulse[1]) r_mode <= MODE_PANEL;
        MODE_PANEL: if (w_pulse[1]) r_mode <= MODE_CPU;
        default:    r_mode <= MODE_CPU;
      endcase

      // A GO press in the same cycle as a CPU clear leaves the flag set.
      if (w_pulse[0])                  r_go <= 1'b1;
      else if (w_cpu_wr && w_is_go)    r_go <= 1'b0;

      if (w_cpu_wr && w_is_disp) r_disp <= cpu.wdata;

      if (w_step_next) begin
        if (r_chunk == CHW'(NCHUNK - 1)) begin
          r_chunk         <= '0;
          r_panel_address <= (r_panel_address == WIDTH'(DEPTH - 1)) ? '0
                             : r_panel_address + WIDTH'(1);
        end else begin
          r_chunk <= r_chunk + CHW'(1);
        end
      end else if (w_step_prev) begin
        if (r_chunk == '0) begin
          r_chunk         <= CHW'(NCHUNK - 1);
          r_panel_address <= (r_panel_address == '0) ? WIDTH'(DEPTH - 1)
                             : r_panel_address - WIDTH'(1);
        end else begin
          r_chunk <= r_chunk - CHW'(1);
        end
      end
    end
  end

  assign mode_led = (r_mode == MODE_PANEL);

  // ---------------------------------------------------------------------------
  // Display
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_chunk_word;
  logic [DW-1:0]    w_data_dat;

  assign w_chunk_word = w_ram_rdata >> (DW * int'(r_chunk));
  assign w_data_dat   = (r_mode == MODE_PANEL) ? w_chunk_word[DW-1:0] : r_disp[DW-1:0];

  for (g = 0; g < NDATA; g++) begin : g_data_dig
    assign seg[g] = hex7(w_data_dat[4*g +: 4]);
  end

  for (g = 0; g < NADDR; g++) begin : g_addr_dig
    assign seg[NDATA+g] = (r_mode == MODE_PANEL) ? hex7(r_panel_address[4*g +: 4]) : 7'h7F;
  end

endmodule

// File: tb/tb_debug_panel_mk2.sv
module tb_debug_panel_mk2;

  localparam int WIDTH     = 32;
  localparam int DEPTH     = 100_000;
  localparam int GO_ADDR   = 100_001;
  localparam int DISP_ADDR = 100_002;
  localparam int DB        = 10;
  localparam int RH        = 40;
  localparam int RP        = 10;
  localparam int NCHUNK    = 2;

  localparam logic [6:0] HEXMAP [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic [3:0]      button = 4'hF;
  logic [5:0][6:0] seg;
  logic            mode_led;

  debug_panel_mk2_if #(.WIDTH(WIDTH)) cpu_if ();

  debug_panel_mk2 #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CLKRATE(1000), .DBMSEC(10), .RPTMSEC(40),
    .NDATA(4), .NADDR(2), .GO_ADDR(GO_ADDR), .DISP_ADDR(DISP_ADDR)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .cpu      (cpu_if),
    .button   (button),
    .seg      (seg),
    .mode_led (mode_led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Panel state is a linear position (address*NCHUNK + chunk) on a ring;
  // button pulses are derived from how long each button has been held.
  bit          m_go, m_mode;
  logic [31:0] m_disp;
  longint      m_pos;
  int          held [4];
  bit          pend [4];
  logic [31:0] ram_m [int];
  bit          cmp_en = 1'b0;
  int          ma;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      m_go = 0; m_mode = 0; m_disp = '0; m_pos = 0;
      for (int i = 0; i < 4; i++) begin held[i] = 0; pend[i] = 0; end
    end else begin
      ma = int'(cpu_if.address);
      if (!m_mode && cpu_if.enw) begin
        if (cpu_if.address == GO_ADDR)        m_go = 0;
        else if (cpu_if.address == DISP_ADDR) m_disp = cpu_if.wdata;
        else if (cpu_if.address < DEPTH)      ram_m[ma] = cpu_if.wdata;
      end
      if (pend[0]) m_go = 1;
      if (m_mode && pend[2] && !pend[3]) m_pos = (m_pos + 1) % (DEPTH * NCHUNK);
      if (m_mode && pend[3] && !pend[2]) m_pos = (m_pos + DEPTH * NCHUNK - 1) % (DEPTH * NCHUNK);
      if (pend[1]) m_mode = !m_mode;
      for (int i = 0; i < 4; i++) begin
        held[i] = button[i] ? 0 : held[i] + 1;
        pend[i] = (held[i] == DB) ||
                  (i >= 2 && held[i] >= DB + RH && (held[i] - DB - RH) % RP == 0);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (nrst && cmp_en) begin
      int          pa, ch;
      logic [15:0] dig;
      bit          dig_ok;
      pa = int'(m_pos / NCHUNK);
      ch = int'(m_pos % NCHUNK);
      chk("mode_led", {31'b0, mode_led}, {31'b0, m_mode});
      dig_ok = 1;
      dig = m_disp[15:0];
      if (m_mode) begin
        if (ram_m.exists(pa)) dig = (ch == 1) ? ram_m[pa][31:16] : ram_m[pa][15:0];
        else dig_ok = 0;
        for (int a = 0; a < 2; a++)
          chk("addr_digit", {25'b0, seg[4+a]}, {25'b0, HEXMAP[(pa >> (4*a)) & 15]});
      end else begin
        for (int a = 0; a < 2; a++)
          chk("addr_blank", {25'b0, seg[4+a]}, 32'h7F);
      end
      if (dig_ok)
        for (int d = 0; d < 4; d++)
          chk("data_digit", {25'b0, seg[d]}, {25'b0, HEXMAP[dig[4*d +: 4]]});
      if (m_mode)                                chk("rdata_panel", cpu_if.rdata, 32'h0);
      else if (cpu_if.address == GO_ADDR)        chk("rdata_go", cpu_if.rdata, {31'b0, m_go});
      else if (cpu_if.address == DISP_ADDR)      chk("rdata_disp", cpu_if.rdata, m_disp);
      else if (ram_m.exists(int'(cpu_if.address))) chk("rdata_ram", cpu_if.rdata, ram_m[int'(cpu_if.address)]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input int idx, input int n);
    button[idx] = 1'b0;
    repeat (n) step();
    button[idx] = 1'b1;
    repeat (3) step();
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    cpu_if.address = a;
    cpu_if.wdata   = d;
    cpu_if.enw     = 1'b1;
    step();
    cpu_if.enw     = 1'b0;
  endtask

  task automatic rd(input string name, input int a, input logic [31:0] exp);
    cpu_if.address = a;
    #1;
    chk(name, cpu_if.rdata, exp);
  endtask

  task automatic seg4(input string name, input logic [6:0] s3, input logic [6:0] s2,
                      input logic [6:0] s1, input logic [6:0] s0);
    chk(name, {4'b0, seg[3], seg[2], seg[1], seg[0]}, {4'b0, s3, s2, s1, s0});
  endtask

  task automatic seg_addr(input string name, input logic [6:0] s5, input logic [6:0] s4);
    chk(name, {18'b0, seg[5], seg[4]}, {18'b0, s5, s4});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    cpu_if.enw     = 1'b0;
    cpu_if.address = '0;
    cpu_if.wdata   = '0;
    repeat (3) step();
    nrst   = 1'b1;
    cmp_en = 1'b1;

    // reset values
    seg4("rst_data", 7'h40, 7'h40, 7'h40, 7'h40);
    seg_addr("rst_addr", 7'h7F, 7'h7F);
    chk("rst_mode_led", {31'b0, mode_led}, 32'h0);
    rd("rst_go", GO_ADDR, 32'h0);

    // debounce: 9 cycles is a glitch, 10 is a press
    press(0, 9);
    rd("go_glitch9", GO_ADDR, 32'h0);
    press(0, 10);
    rd("go_press10", GO_ADDR, 32'h1);
    wr(GO_ADDR, 32'h0);
    rd("go_cleared", GO_ADDR, 32'h0);

    // GO pulse coincides with CPU clear: pulse wins
    button[0] = 1'b0;
    repeat (10) step();
    cpu_if.address = GO_ADDR;
    cpu_if.enw     = 1'b1;
    step();
    cpu_if.enw = 1'b0;
    button[0]  = 1'b1;
    step();
    rd("go_race", GO_ADDR, 32'h1);
    wr(GO_ADDR, 32'h0);
    rd("go_clear2", GO_ADDR, 32'h0);

    // display register
    wr(DISP_ADDR, 32'h0000BEEF);
    seg4("disp_beef", 7'h03, 7'h06, 7'h06, 7'h0E);
    rd("disp_read", DISP_ADDR, 32'h0000BEEF);

    // paging
    wr(0, 32'h12345678);
    wr(1, 32'h9ABCDEF0);
    wr(5, 32'h11111111);
    rd("ram0_read", 0, 32'h12345678);
    press(1, 10);
    chk("mode_panel", {31'b0, mode_led}, 32'h1);
    seg4("page_5678", 7'h12, 7'h02, 7'h78, 7'h00);
    seg_addr("page_addr00", 7'h40, 7'h40);
    press(2, 10);
    seg4("page_1234", 7'h79, 7'h24, 7'h30, 7'h19);
    press(2, 10);
    seg4("page_def0", 7'h21, 7'h06, 7'h0E, 7'h40);
    seg_addr("page_addr01", 7'h40, 7'h79);
    press(3, 10);
    press(3, 10);
    seg4("page_back", 7'h12, 7'h02, 7'h78, 7'h00);
    seg_addr("page_back_addr", 7'h40, 7'h40);
    press(3, 10);
    seg_addr("wrap_to_top", 7'h10, 7'h0E);   // 99999 = 0x1869F
    press(2, 10);
    seg4("wrap_to_zero", 7'h12, 7'h02, 7'h78, 7'h00);
    seg_addr("wrap_zero_addr", 7'h40, 7'h40);

    // auto-repeat: 70 held cycles -> 4 moves -> address 2, chunk 0
    press(2, 70);
    seg_addr("repeat_addr02", 7'h40, 7'h24);
    button[3:2] = 2'b00;
    repeat (55) step();
    button[3:2] = 2'b11;
    repeat (3) step();
    seg_addr("both_no_move", 7'h40, 7'h24);

    // panel isolation
    wr(5, 32'hCAFEF00D);
    wr(DISP_ADDR, 32'h00001234);
    rd("panel_rdata0", 5, 32'h0);
    press(0, 10);                    // GO works in panel mode
    press(1, 10);
    chk("mode_cpu", {31'b0, mode_led}, 32'h0);
    seg4("disp_kept", 7'h03, 7'h06, 7'h06, 7'h0E);
    rd("ram5_kept", 5, 32'h11111111);
    rd("go_from_panel", GO_ADDR, 32'h1);
    wr(5, 32'hCAFEF00D);
    rd("ram5_lands", 5, 32'hCAFEF00D);

    step();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
